keystream_sched: RTL and testbench

- Controller that sequences the shared 32-bit LFSR keystream generator and shares it between two requesters (encrypt channel = 0, decrypt channel = 1).
- Drives the LFSR enable line, runs a warm-up phase after every seed load, and arbitrates key-word requests round-robin.
- Registers each granted key word with a valid/ack handshake.
- Forces an automatic reseed after a programmable number of issued keys.

---
 rtl/keystream_sched.sv | 159 +++++++++++++++
 tb/tb_keystream_sched.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/keystream_sched.sv
// keystream_sched
//   Sequences a shared 32-bit LFSR keystream generator and shares it between
//   two requesters (channel 0 = encrypt, channel 1 = decrypt). After every
//   seed load the LFSR free-runs for WARMUP cycles. Key words are then issued
//   round-robin through a registered valid/ack holding stage. After
//   REKEY_INTERVAL issued keys an automatic reseed is forced (0 disables it).
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-low
//   req        in   [1:0] level request per channel (bit0 enc, bit1 dec)
//   reseed     in   single-cycle pulse restarting the LFSR from its seed
//   lfsr_y     in   [BLOCK_SIZE-1:0] current LFSR output word
//   lfsr_en    out  LFSR enable (0 = load seed, 1 = advance one step)
//   key        out  [BLOCK_SIZE-1:0] registered key word
//   key_valid  out  key holds a word for key_owner
//   key_owner  out  channel index owning key
//   key_ack    in   consumer accepts key (only meaningful with key_valid)
//   gnt        out  [1:0] one-hot grant pulse, in the cycle lfsr_y is captured
//   ready      out  high while in RUN
module keystream_sched #(
  parameter int BLOCK_SIZE     = 32,
  parameter int WARMUP         = 16,
  parameter int REKEY_INTERVAL = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic                  reseed,
  input  logic [BLOCK_SIZE-1:0] lfsr_y,
  output logic                  lfsr_en,
  output logic [BLOCK_SIZE-1:0] key,
  output logic                  key_valid,
  output logic                  key_owner,
  input  logic                  key_ack,
  output logic [1:0]            gnt,
  output logic                  ready
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARM   = 2'd1,
    S_RUN    = 2'd2,
    S_RESEED = 2'd3
  } state_t;

  localparam logic [7:0]  WARM_LAST = 8'(WARMUP - 1);
  localparam logic [16:0] REKEY_L   = 17'(REKEY_INTERVAL);
  localparam bit          REKEY_EN  = (REKEY_INTERVAL != 0);

  state_t                  state_q, state_d;
  logic [7:0]              warm_q, warm_d;
  logic [15:0]             issue_q, issue_d;
  logic                    pref_q, pref_d;   // channel that wins a tie
  logic [BLOCK_SIZE-1:0]   key_q, key_d;
  logic                    valid_q, valid_d;
  logic                    owner_q, owner_d;

  logic                    grant;
  logic                    winner;
  logic [16:0]             issue_inc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      warm_q  <= '0;
      issue_q <= '0;
      pref_q  <= 1'b0;
      key_q   <= '0;
      valid_q <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      issue_q <= issue_d;
      pref_q  <= pref_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    warm_d    = warm_q;
    issue_d   = issue_q;
    pref_d    = pref_q;
    key_d     = key_q;
    valid_d   = valid_q;
    owner_d   = owner_q;
    gnt       = 2'b00;
    issue_inc = {1'b0, issue_q} + 17'd1;

    // Single requester wins outright; on a tie the pointer decides.
    winner = (req == 2'b11) ? pref_q : req[1];

    // A reseed pulse in RUN takes priority over a grant in the same cycle.
    // The holding stage may be refilled in the cycle its word is acked.
    grant = rst && (state_q == S_RUN) && (req != 2'b00) &&
            (!valid_q || key_ack) && !reseed;

    if (grant) begin
      gnt     = winner ? 2'b10 : 2'b01;
      key_d   = lfsr_y;
      owner_d = winner;
      valid_d = 1'b1;
      pref_d  = ~winner;
    end else if (key_ack && valid_q) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        warm_d  = '0;
        state_d = S_WARM;
      end
      S_WARM: begin
        if (reseed) begin
          issue_d = '0;
          state_d = S_RESEED;
        end else if (warm_q == WARM_LAST) begin
          warm_d  = '0;
          state_d = S_RUN;
        end else begin
          warm_d  = warm_q + 8'd1;
        end
      end
      S_RUN: begin
        if (reseed) begin
          issue_d = '0;
          state_d = S_RESEED;
        end else if (grant) begin
          // The grant that reaches the interval still completes normally.
          if (REKEY_EN && (issue_inc == REKEY_L)) begin
            issue_d = '0;
            state_d = S_RESEED;
          end else begin
            issue_d = issue_inc[15:0];
          end
        end
      end
      S_RESEED: begin
        warm_d  = '0;
        state_d = S_WARM;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The LFSR reloads its seed whenever the enable is low (IDLE, RESEED).
  assign lfsr_en   = (state_q == S_WARM) || (state_q == S_RUN);
  assign ready     = (state_q == S_RUN);
  assign key       = key_q;
  assign key_valid = valid_q;
  assign key_owner = owner_q;

endmodule

// File: tb/tb_keystream_sched.sv
module tb_keystream_sched;

  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: WARMUP=4, auto-reseed disabled
  logic        rst, reseed, key_ack;
  logic [1:0]  req;
  logic [31:0] lfsr_a;
  logic        lfsr_en, key_valid, key_owner, ready;
  logic [31:0] key;
  logic [1:0]  gnt;

  // Rekey instance: WARMUP=4, REKEY_INTERVAL=3
  logic        rst_rk, reseed_rk, ack_rk;
  logic [1:0]  req_rk;
  logic [31:0] lfsr_b;
  logic        en_rk, val_rk, own_rk, rdy_rk;
  logic [31:0] key_rk;
  logic [1:0]  gnt_rk;

  int n_vec = 0;
  int n_mis = 0;

  function automatic logic [31:0] lstep(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'hA300_0000) : (x >> 1);
  endfunction

  function automatic logic [31:0] s(input int n);
    logic [31:0] x;
    x = SEED;
    for (int i = 0; i < n; i++) x = lstep(x);
    return x;
  endfunction

  // Behavioural keystream generators driven by each controller's enable
  always @(posedge clk) lfsr_a <= lfsr_en ? lstep(lfsr_a) : SEED;
  always @(posedge clk) lfsr_b <= en_rk   ? lstep(lfsr_b) : SEED;

  keystream_sched #(.BLOCK_SIZE(32), .WARMUP(4), .REKEY_INTERVAL(0)) u_dut (
    .clk(clk), .rst(rst), .req(req), .reseed(reseed), .lfsr_y(lfsr_a),
    .lfsr_en(lfsr_en), .key(key), .key_valid(key_valid),
    .key_owner(key_owner), .key_ack(key_ack), .gnt(gnt), .ready(ready));

  keystream_sched #(.BLOCK_SIZE(32), .WARMUP(4), .REKEY_INTERVAL(3)) u_rk (
    .clk(clk), .rst(rst_rk), .req(req_rk), .reseed(reseed_rk), .lfsr_y(lfsr_b),
    .lfsr_en(en_rk), .key(key_rk), .key_valid(val_rk),
    .key_owner(own_rk), .key_ack(ack_rk), .gnt(gnt_rk), .ready(rdy_rk));

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic        ack;
    logic        rs;
    logic        en;
    logic        rdy;
    logic [1:0]  gnt;
    logic        val;
    logic        own;
    logic [31:0] key;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic [1:0] rq, input logic a,
                              input logic rs, input logic en, input logic rdy,
                              input logic [1:0] g, input logic v, input logic o,
                              input logic [31:0] k);
    vec_t t;
    t.rst = r; t.req = rq; t.ack = a; t.rs = rs;
    t.en = en; t.rdy = rdy; t.gnt = g; t.val = v; t.own = o; t.key = k;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @%0d: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] m_en, m_rdy, m_gnt, m_val;
    int          kst[16];

    rst = 1'b0; req = 2'b00; reseed = 1'b0; key_ack = 1'b0;
    rst_rk = 1'b0; req_rk = 2'b00; reseed_rk = 1'b0; ack_rk = 1'b0;

    // Stimulus/expectation table for the main instance
    // reset release with req=01, first grant at the first RUN cycle
    vq.push_back(mk(1, 2'b01, 0, 0, 0, 0, 2'b00, 0, 0, 32'h0));
    for (int i = 0; i < 4; i++) vq.push_back(mk(1, 2'b01, 0, 0, 1, 0, 2'b00, 0, 0, 32'h0));
    vq.push_back(mk(1, 2'b01, 0, 0, 1, 1, 2'b01, 0, 0, 32'h0));
    vq.push_back(mk(1, 2'b01, 0, 0, 1, 1, 2'b00, 1, 0, s(4)));
    // both request, ack high: alternating back-to-back grants
    vq.push_back(mk(1, 2'b11, 1, 0, 1, 1, 2'b10, 1, 0, s(4)));
    vq.push_back(mk(1, 2'b11, 1, 0, 1, 1, 2'b01, 1, 1, s(6)));
    vq.push_back(mk(1, 2'b11, 1, 0, 1, 1, 2'b10, 1, 0, s(7)));
    vq.push_back(mk(1, 2'b11, 1, 0, 1, 1, 2'b01, 1, 1, s(8)));
    // ack withheld 3 cycles, grant in the ack cycle
    for (int i = 0; i < 3; i++) vq.push_back(mk(1, 2'b11, 0, 0, 1, 1, 2'b00, 1, 0, s(9)));
    vq.push_back(mk(1, 2'b11, 1, 0, 1, 1, 2'b10, 1, 0, s(9)));
    vq.push_back(mk(1, 2'b00, 0, 0, 1, 1, 2'b00, 1, 1, s(13)));
    // plain ack drops valid, key holds; ack with valid low is ignored
    vq.push_back(mk(1, 2'b00, 1, 0, 1, 1, 2'b00, 1, 1, s(13)));
    vq.push_back(mk(1, 2'b00, 0, 0, 1, 1, 2'b00, 0, 1, s(13)));
    vq.push_back(mk(1, 2'b00, 1, 0, 1, 1, 2'b00, 0, 1, s(13)));
    // reseed blocks a same-cycle grant
    vq.push_back(mk(1, 2'b01, 0, 1, 1, 1, 2'b00, 0, 1, s(13)));
    vq.push_back(mk(1, 2'b01, 0, 0, 0, 0, 2'b00, 0, 1, s(13)));
    for (int i = 0; i < 4; i++) vq.push_back(mk(1, 2'b01, 0, 0, 1, 0, 2'b00, 0, 1, s(13)));
    vq.push_back(mk(1, 2'b01, 0, 0, 1, 1, 2'b01, 0, 1, s(13)));
    // pending key survives reseed and warm-up
    vq.push_back(mk(1, 2'b00, 0, 1, 1, 1, 2'b00, 1, 0, s(4)));
    vq.push_back(mk(1, 2'b01, 0, 0, 0, 0, 2'b00, 1, 0, s(4)));
    for (int i = 0; i < 4; i++) vq.push_back(mk(1, 2'b01, 0, 0, 1, 0, 2'b00, 1, 0, s(4)));
    vq.push_back(mk(1, 2'b01, 0, 0, 1, 1, 2'b00, 1, 0, s(4)));
    vq.push_back(mk(1, 2'b01, 1, 0, 1, 1, 2'b01, 1, 0, s(4)));
    // reset while a key is pending, then restart with a tie (pointer at 0)
    vq.push_back(mk(0, 2'b01, 0, 0, 1, 1, 2'b00, 1, 0, s(5)));
    vq.push_back(mk(0, 2'b11, 0, 0, 0, 0, 2'b00, 0, 0, 32'h0));
    vq.push_back(mk(1, 2'b11, 0, 0, 0, 0, 2'b00, 0, 0, 32'h0));
    for (int i = 0; i < 4; i++) vq.push_back(mk(1, 2'b11, 0, 0, 1, 0, 2'b00, 0, 0, 32'h0));
    vq.push_back(mk(1, 2'b11, 0, 0, 1, 1, 2'b01, 0, 0, 32'h0));
    vq.push_back(mk(1, 2'b00, 1, 0, 1, 1, 2'b00, 1, 0, s(4)));
    vq.push_back(mk(1, 2'b00, 0, 0, 1, 1, 2'b00, 0, 0, s(4)));

    // Reset state of both instances
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    chk("rst_lfsr_en", 0, 32'(lfsr_en), 32'h0);
    chk("rst_ready", 0, 32'(ready), 32'h0);
    chk("rst_gnt", 0, 32'(gnt), 32'h0);
    chk("rst_valid", 0, 32'(key_valid), 32'h0);
    chk("rst_owner", 0, 32'(key_owner), 32'h0);
    chk("rst_key", 0, key, 32'h0);
    chk("rst_rk_valid", 0, 32'(val_rk), 32'h0);
    chk("rst_rk_key", 0, key_rk, 32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst = vq[i].rst; req = vq[i].req; key_ack = vq[i].ack; reseed = vq[i].rs;
      #1;
      n_vec++;
      chk("lfsr_en", i, 32'(lfsr_en), 32'(vq[i].en));
      chk("ready", i, 32'(ready), 32'(vq[i].rdy));
      chk("gnt", i, 32'(gnt), 32'(vq[i].gnt));
      chk("key_valid", i, 32'(key_valid), 32'(vq[i].val));
      chk("key_owner", i, 32'(key_owner), 32'(vq[i].own));
      chk("key", i, key, vq[i].key);
    end

    // Auto-reseed after 3 keys: 4th key repeats the 1st
    m_en  = 16'b1111_1110_1111_1110;
    m_rdy = 16'b1110_0000_1110_0000;
    m_gnt = 16'b1110_0000_1110_0000;
    m_val = 16'b1100_0001_1100_0000;
    kst   = '{-1, -1, -1, -1, -1, -1, 4, 5, 6, 6, 6, 6, 6, 6, 4, 5};
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 0) begin
        rst_rk = 1'b1; req_rk = 2'b01; ack_rk = 1'b1;
      end
      #1;
      n_vec++;
      chk("rk_lfsr_en", c, 32'(en_rk), 32'(m_en[c]));
      chk("rk_ready", c, 32'(rdy_rk), 32'(m_rdy[c]));
      chk("rk_gnt", c, 32'(gnt_rk), m_gnt[c] ? 32'h1 : 32'h0);
      chk("rk_valid", c, 32'(val_rk), 32'(m_val[c]));
      chk("rk_key", c, key_rk, (kst[c] < 0) ? 32'h0 : s(kst[c]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
